// File: rtl/mode_seq_pkg.sv
// mode_seq_pkg: shared types and 7-segment constants for the mode sequencer.
package mode_seq_pkg;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0][7:0] SEG_MODE = {8'b11111111, 8'b01001001, 8'b00010001, 8'b10000101};
    typedef logic [1:0] mode_t;
    typedef enum logic {S_RUN, S_BLANK} state_t;
endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: 2-FF synchronizer, stability counter and press (falling-edge) strobe.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press_evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic sync1_q, sync2_q, level_q, press_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // any sample matching the current level is a bounce and restarts the count
            if (sync2_q == level_q) cnt_q <= '0;
            else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
                press_q <= ~sync2_q;
            end else cnt_q <= cnt_q + CW'(1);
        end
    end
    assign level     = level_q;
    assign press_evt = press_q;
endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: debounced button cycles display modes, muxes the selected
// source digits onto seg1/seg0 and blanks them for a while after each change.
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter int NUM_MODES       = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLANK_CYCLES    = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_n,
    input  logic [NUM_MODES-1:0][7:0] src_seg1,
    input  logic [NUM_MODES-1:0][7:0] src_seg0,
    output logic [7:0]                seg3,
    output logic [7:0]                seg1,
    output logic [7:0]                seg0,
    output mode_t                     mode,
    output logic                      mode_pulse
);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);
    logic btn_level, press_evt, pulse_q;
    mode_t mode_q, nxt_mode;
    state_t state_q;
    logic [BW-1:0] cnt_q;
    logic [7:0] seg3_q, seg1_q, seg0_q, src1, src0;
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk      (clk),
        .reset    (reset),
        .btn_n    (btn_n),
        .level    (btn_level),
        .press_evt(press_evt)
    );
    // modes without a source (illegal index) show blank digits
    always_comb begin
        src1 = SEG_OFF;
        src0 = SEG_OFF;
        for (int i = 0; i < NUM_MODES; i++)
            if (mode_q == mode_t'(i)) begin
                src1 = src_seg1[i];
                src0 = src_seg0[i];
            end
    end
    assign nxt_mode = (mode_q >= mode_t'(NUM_MODES - 1)) ? '0 : mode_q + 1'b1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BLANK;
            cnt_q   <= BLANK_LOAD;
            mode_q  <= '0;
            seg3_q  <= SEG_MODE[0];
            seg1_q  <= SEG_OFF;
            seg0_q  <= SEG_OFF;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (state_q == S_RUN) begin
                seg1_q <= src1;
                seg0_q <= src0;
                if (press_evt && !btn_level) begin
                    mode_q  <= nxt_mode;
                    seg3_q  <= SEG_MODE[nxt_mode];
                    pulse_q <= 1'b1;
                    cnt_q   <= BLANK_LOAD;
                    state_q <= S_BLANK;
                    seg1_q  <= SEG_OFF;
                    seg0_q  <= SEG_OFF;
                end
            end else begin
                seg1_q <= SEG_OFF;
                seg0_q <= SEG_OFF;
                if (cnt_q == BW'(1)) state_q <= S_RUN;
                else cnt_q <= cnt_q - BW'(1);
            end
        end
    end
    assign seg3       = seg3_q;
    assign seg1       = seg1_q;
    assign seg0       = seg0_q;
    assign mode       = mode_q;
    assign mode_pulse = pulse_q;
endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: directed checks of debounce, mode cycling, blanking and reset.
module tb_mode_sequencer;
    logic clk = 1'b0, reset = 1'b1, btn_n = 1'b1, btn2_n = 1'b1;
    logic [2:0][7:0] s1 = {8'h31, 8'h21, 8'h11};
    logic [2:0][7:0] s0 = {8'h32, 8'h22, 8'h12};
    logic [7:0] seg3, seg1, seg0, seg3_b, seg1_b, seg0_b;
    logic [1:0] mode, mode_b;
    logic mode_pulse, mode_pulse_b;
    int n_chk = 0, n_err = 0;
    int first, cnt;
    logic [15:0] pre, post;
    always #5 clk = ~clk;
    mode_sequencer #(.NUM_MODES(3), .DEBOUNCE_CYCLES(4), .BLANK_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .btn_n(btn_n), .src_seg1(s1), .src_seg0(s0),
        .seg3(seg3), .seg1(seg1), .seg0(seg0), .mode(mode), .mode_pulse(mode_pulse)
    );
    mode_sequencer #(.NUM_MODES(3), .DEBOUNCE_CYCLES(4), .BLANK_CYCLES(40)) dut_b (
        .clk(clk), .reset(reset), .btn_n(btn2_n), .src_seg1(s1), .src_seg0(s0),
        .seg3(seg3_b), .seg1(seg1_b), .seg0(seg0_b), .mode(mode_b), .mode_pulse(mode_pulse_b)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // hold the button low for 'low' cycles within an 'n'-cycle window on dut
    task automatic press(input int low, input int n, output int f, output int c,
                         output logic [15:0] p3, output logic [15:0] p4);
        f = -1; c = 0; p3 = '0; p4 = '0;
        btn_n = 1'b0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (mode_pulse) begin
                c++;
                if (f < 0) f = i;
            end
            if (f >= 0 && i == f + 3) p3 = {seg1, seg0};
            if (f >= 0 && i == f + 4) p4 = {seg1, seg0};
            if (i == low) btn_n = 1'b1;
        end
    endtask
    initial begin
        tick();
        tick();
        check("rst_mode", mode, 0);
        check("rst_seg3", seg3, 8'b10000101);
        check("rst_seg10", {seg1, seg0}, 16'hFFFF);
        check("rst_pulse", mode_pulse, 0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (mode_pulse) cnt++;
            if (i == 3) pre = {seg1, seg0};
            if (i == 4) post = {seg1, seg0};
        end
        check("idle_blank", pre, 16'hFFFF);
        check("idle_run", post, 16'h1112);
        check("idle_pulses", cnt, 0);
        check("idle_seg3", seg3, 8'b10000101);
        press(20, 20, first, cnt, pre, post);
        check("hold_latency", first, 7);
        check("hold_pulses", cnt, 1);
        check("hold_mode", mode, 1);
        check("hold_seg3", seg3, 8'b00010001);
        check("hold_blank", pre, 16'hFFFF);
        check("hold_run", post, 16'h2122);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            btn_n = (i < 20) ? (((i / 2) % 2) == 1) : 1'b1;
            tick();
            if (mode_pulse) cnt++;
        end
        check("bounce_pulses", cnt, 0);
        check("bounce_mode", mode, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        press(8, 18, first, cnt, pre, post);
        check("p1_mode", mode, 1);
        check("p1_pulses", cnt, 1);
        press(8, 18, first, cnt, pre, post);
        check("p2_mode", mode, 2);
        check("p2_seg3", seg3, 8'b01001001);
        check("p2_run", post, 16'h3132);
        press(8, 18, first, cnt, pre, post);
        check("p3_mode", mode, 0);
        check("p3_seg3", seg3, 8'b10000101);
        check("p3_run", post, 16'h1112);
        first = -1; cnt = 0; pre = '0; post = '0;
        btn2_n = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (mode_pulse_b) begin
                cnt++;
                if (first < 0) first = i;
            end
            if (first >= 0 && i == first + 40) pre = {seg1_b, seg0_b};
            if (first >= 0 && i == first + 41) post = {seg1_b, seg0_b};
            if (i == 8 || i == 24) btn2_n = 1'b1;
            if (i == 16) btn2_n = 1'b0;
        end
        check("blk_first", first, 7);
        check("blk_pulses", cnt, 1);
        check("blk_mode", mode_b, 1);
        check("blk_seg3", seg3_b, 8'b00010001);
        check("blk_blank", pre, 16'hFFFF);
        check("blk_run", post, 16'h2122);
        press(8, 18, first, cnt, pre, post);
        check("r_p1_mode", mode, 1);
        btn_n = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && cnt == 0; i++) begin
            tick();
            if (mode_pulse) cnt++;
        end
        check("r_pulse_seen", cnt, 1);
        tick();
        tick();
        check("r_mode2", mode, 2);
        check("r_midblank", {seg1, seg0}, 16'hFFFF);
        reset = 1'b1;
        #1;
        check("r_mode", mode, 0);
        check("r_seg3", seg3, 8'b10000101);
        check("r_seg10", {seg1, seg0}, 16'hFFFF);
        check("r_pulse", mode_pulse, 0);
        btn_n = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 3) pre = {seg1, seg0};
            if (i == 4) post = {seg1, seg0};
        end
        check("r_blank", pre, 16'hFFFF);
        check("r_run", post, 16'h1112);
        check("r_mode_after", mode, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
